prog_timer: RTL and testbench

Programmable interval timer for game-timing uses such as mole pop-up windows, round clocks and debounce periods. It generalises the fixed up-counter with the following features:
- runtime terminal count
- up or down direction
- one-shot or periodic (auto-reload) mode
- clock prescaler
- pause, abort and a done flag

A single instance replaces a chain of fixed counters plus glue logic.

---
 rtl/prog_timer.sv | 115 +++++++++++
 tb/tb_prog_timer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_timer.sv
// prog_timer: programmable interval timer with runtime terminal count,
// up/down direction, one-shot or periodic mode, clock prescaler,
// pause, abort and a done flag. All outputs are registered.
module prog_timer #(
   parameter int WIDTH     = 8,
   parameter int PRE_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 pause,
   input  logic                 mode,
   input  logic                 dir,
   input  logic [WIDTH-1:0]     term_cnt,
   input  logic [PRE_WIDTH-1:0] prescale,
   output logic [WIDTH-1:0]     count,
   output logic                 timer,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0]     CNT_ONE = WIDTH'(1);
   localparam logic [PRE_WIDTH-1:0] PRE_ONE = PRE_WIDTH'(1);

   state_t               state;
   logic [PRE_WIDTH-1:0] pre_cnt;
   logic                 mode_l;
   logic                 dir_l;
   logic [WIDTH-1:0]     term_l;
   logic [PRE_WIDTH-1:0] pre_l;

   // Tick and terminal detection from the current registered values.
   logic tick;
   logic terminal;
   assign tick     = (pre_cnt == pre_l);
   assign terminal = dir_l ? (count == '0) : (count == term_l);

   // Timer state machine: priority reset > stop > start > pause > tick.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // read in this block sees the value from before the edge.
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         pre_cnt <= '0;
         timer   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         mode_l  <= 1'b0;
         dir_l   <= 1'b0;
         term_l  <= '0;
         pre_l   <= '0;
      end else if (stop) begin
         // Abort wins over a coincident terminal tick: no pulse.
         state   <= IDLE;
         count   <= '0;
         pre_cnt <= '0;
         timer   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (start) begin
         // (Re)start from any state; configuration is frozen until the next start.
         mode_l  <= mode;
         dir_l   <= dir;
         term_l  <= term_cnt;
         pre_l   <= prescale;
         pre_cnt <= '0;
         count   <= dir ? term_cnt : '0;
         state   <= RUN;
         timer   <= 1'b0;
         busy    <= 1'b1;
         done    <= 1'b0;
      end else begin
         timer <= 1'b0;
         case (state)
            RUN, PAUSED: begin
               if (pause) begin
                  state <= PAUSED;
               end else begin
                  state <= RUN;
                  if (tick) begin
                     pre_cnt <= '0;
                     if (terminal) begin
                        timer <= 1'b1;
                        if (mode_l) begin
                           // Periodic: reload and keep running.
                           count <= dir_l ? term_l : '0;
                        end else begin
                           // One-shot: count holds its terminal value.
                           state <= DONE;
                           busy  <= 1'b0;
                           done  <= 1'b1;
                        end
                     end else begin
                        count <= dir_l ? (count - CNT_ONE) : (count + CNT_ONE);
                     end
                  end else begin
                     pre_cnt <= pre_cnt + PRE_ONE;
                  end
               end
            end
            default: ;  // IDLE and DONE hold everything
         endcase
      end
   end

endmodule

// File: tb/tb_prog_timer.sv
// tb_prog_timer: directed scenarios plus randomized stimulus, checked every
// cycle against an elapsed-cycle arithmetic model of the timer.
module tb_prog_timer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       pause = 1'b0;
   logic       mode = 1'b0;
   logic       dir = 1'b0;
   logic [7:0] term_cnt = '0;
   logic [3:0] prescale = '0;
   logic [7:0] count;
   logic       timer;
   logic       busy;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   prog_timer #(.WIDTH(8), .PRE_WIDTH(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .mode     (mode),
      .dir      (dir),
      .term_cnt (term_cnt),
      .prescale (prescale),
      .count    (count),
      .timer    (timer),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // Reference model: elapsed unpaused run cycles since start (m_e) fully
   // determine the tick count, and from it count/timer/done by arithmetic.
   bit m_run, m_done, m_timer, m_mode, m_dir;
   int m_e, m_t, m_p, m_count;

   always @(posedge clk) begin
      int k;
      if (reset) begin
         m_run = 0; m_done = 0; m_timer = 0; m_count = 0;
         m_mode = 0; m_dir = 0; m_t = 0; m_p = 0; m_e = 0;
      end else if (stop) begin
         m_run = 0; m_done = 0; m_timer = 0; m_count = 0;
      end else if (start) begin
         m_mode = mode; m_dir = dir; m_t = int'(term_cnt); m_p = int'(prescale);
         m_e = 0; m_run = 1; m_done = 0; m_timer = 0;
         m_count = dir ? m_t : 0;
      end else if (m_run && !pause) begin
         m_e++;
         k = m_e / (m_p + 1);
         m_timer = (m_e % (m_p + 1) == 0) && (k % (m_t + 1) == 0);
         if (!m_mode && k >= m_t + 1) begin
            m_run = 0;
            m_done = 1;
            m_count = m_dir ? 0 : m_t;
         end else begin
            m_count = m_dir ? (m_t - k % (m_t + 1)) : (k % (m_t + 1));
         end
      end else begin
         m_timer = 0;
      end
   end

   // Per-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         check("model_count", int'(count), m_count);
         check("model_timer", int'(timer), int'(m_timer));
         check("model_busy",  int'(busy),  int'(m_run));
         check("model_done",  int'(done),  int'(m_done));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start(input bit md, input bit dr, input int tc, input int ps);
      mode = md; dir = dr; term_cnt = tc[7:0]; prescale = ps[3:0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   int r;

   initial begin
      cyc(2);
      check("reset_count", int'(count), 0);
      check("reset_busy",  int'(busy),  0);
      check("reset_timer", int'(timer), 0);
      reset = 1'b0;
      chk_en = 1'b1;

      // Periodic up, term 3, prescale 0.
      pulse_start(1, 0, 3, 0);
      check("p_up_start", int'(count), 0);
      check("p_up_busy", int'(busy), 1);
      cyc(3);
      check("p_up_at3", int'(count), 3);
      cyc(1);
      check("p_up_wrap", int'(count), 0);
      check("p_up_pulse", int'(timer), 1);
      cyc(1);
      check("p_up_pulse_end", int'(timer), 0);

      // One-shot down, term 5, prescale 1.
      pulse_start(0, 1, 5, 1);
      check("os_dn_start", int'(count), 5);
      cyc(11);
      check("os_dn_zero", int'(count), 0);
      check("os_dn_nopulse", int'(timer), 0);
      cyc(1);
      check("os_dn_pulse", int'(timer), 1);
      check("os_dn_done", int'(done), 1);
      check("os_dn_busy", int'(busy), 0);
      cyc(20);
      check("os_dn_hold", int'(count), 0);

      // Pause at count 4 for 5 cycles.
      pulse_start(1, 0, 7, 0);
      cyc(4);
      check("pz_at4", int'(count), 4);
      pause = 1'b1;
      cyc(5);
      check("pz_frozen", int'(count), 4);
      check("pz_busy", int'(busy), 1);
      pause = 1'b0;
      cyc(3);
      check("pz_at7", int'(count), 7);
      cyc(1);
      check("pz_wrap_pulse", int'(timer), 1);

      // Stop on the terminal-tick cycle.
      pulse_start(1, 0, 2, 0);
      cyc(2);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      check("stop_nopulse", int'(timer), 0);
      check("stop_count", int'(count), 0);
      check("stop_busy", int'(busy), 0);

      // Start and stop together: stop wins.
      start = 1'b1; stop = 1'b1;
      cyc(1);
      start = 1'b0; stop = 1'b0;
      check("ss_busy", int'(busy), 0);

      // Start while pause high.
      pause = 1'b1;
      pulse_start(1, 1, 4, 0);
      check("sp_count", int'(count), 4);
      check("sp_busy", int'(busy), 1);
      cyc(2);
      check("sp_held", int'(count), 4);
      pause = 1'b0;

      // Restart mid-run with a new term.
      pulse_start(1, 0, 10, 0);
      cyc(6);
      check("rs_at6", int'(count), 6);
      pulse_start(1, 0, 2, 0);
      check("rs_restart", int'(count), 0);
      cyc(3);
      check("rs_wrap_pulse", int'(timer), 1);

      // term 0, prescale 3: pulse every 4 cycles.
      pulse_start(1, 0, 0, 3);
      cyc(3);
      check("t0_nopulse", int'(timer), 0);
      cyc(1);
      check("t0_pulse", int'(timer), 1);
      check("t0_count", int'(count), 0);

      // Reset mid-run at count 9.
      pulse_start(1, 0, 255, 0);
      cyc(9);
      check("rr_at9", int'(count), 9);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      check("rr_count", int'(count), 0);
      check("rr_busy", int'(busy), 0);
      pulse_start(0, 1, 3, 0);
      check("rr_restart", int'(count), 3);

      // Randomized phase; config inputs also wiggle mid-run.
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 199);
         reset = (r < 2);
         stop = ($urandom_range(0, 59) == 0);
         start = ($urandom_range(0, 24) == 0);
         pause = ($urandom_range(0, 4) == 0);
         mode = 1'($urandom);
         dir = 1'($urandom);
         term_cnt = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
         prescale = 4'($urandom);
         cyc(1);
      end
      reset = 1'b0; stop = 1'b0; start = 1'b0; pause = 1'b0;
      cyc(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
